mapper_mem_arbiter: RTL and testbench
=====================================

Name: mapper_mem_arbiter

Overview:
- Shares the single external ROM/RAM memory port between two requesters.
  - The CPU-side mapper output: address already translated by the active slot mapper.
  - The ROM/RAM loader: image download and initialisation writes.
- Sequences each access with a req/ack handshake and stalls the Z80 through a wait output.
- CPU has priority; a starvation guard guarantees the loader progresses.
- Sits between the mapper output mux and the memory controller.

Parameters:
ADDR_W, 27, width of translated memory address
STARVE_MAX, 4, consecutive CPU grants allowed while loader is pending before loader is forced in (1..15)

Ports:
clk  in  1  system clock (cpu_bus clock domain)
reset  in  1  synchronous, active-high reset
cpu_req  in  1  single-cycle strobe marking start of a CPU bus cycle
cpu_cs  in  1  mapper output ram_cs (access targets memory)
cpu_rd  in  1  CPU read
cpu_wr  in  1  CPU write
cpu_addr  in  ADDR_W  translated address from mapper
cpu_din  in  8  CPU write data
cpu_dout  out  8  CPU read data
cpu_wait  out  1  stall request to Z80 WAIT logic
ldr_req  in  1  loader request, level, held until ldr_ack
ldr_addr  in  ADDR_W  loader address
ldr_din  in  8  loader write data (loader always writes)
ldr_ack  out  1  one-cycle completion pulse to loader
mem_req  out  1  memory request, level
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_din  out  8  memory write data
mem_dout  in  8  memory read data, valid with mem_ack
mem_ack  in  1  one-cycle completion pulse from memory

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - mem_req=0, mem_we=0, mem_addr=0, mem_din=0
  - ldr_ack=0, cpu_dout=8'hFF (open bus)
  - cpu_pending=0, starve=0, state=IDLE
- CPU accept:
  - accept = cpu_req & cpu_cs & (cpu_rd|cpu_wr) & ~cpu_pending.
  - On accept, latch addr, din, wr into CPU holding registers and set cpu_pending.
  - A strobe while pending is ignored.
- cpu_wait = cpu_pending | accept (combinational). It is high in the strobe cycle itself.
- FSM states: IDLE, CPU_BUSY, LDR_BUSY.
- In IDLE, let cpu_ready = cpu_pending | accept:
  - cpu_ready & ~(ldr_req & starve==STARVE_MAX) -> CPU_BUSY.
    - Next edge: mem_req=1, mem_addr/mem_din/mem_we from CPU request (accept-cycle inputs bypass the holding regs).
  - else ldr_req -> LDR_BUSY.
    - Next edge: mem_req=1, mem_we=1, ldr_addr/ldr_din.
  - else stay in IDLE.
- Busy states:
  - mem_req, mem_we, mem_addr and mem_din are held stable until mem_ack.
  - On mem_ack: mem_req and mem_we go to 0 at that edge, state -> IDLE.
  - mem_req is therefore low at least one cycle between transactions.
- CPU completion (mem_ack in CPU_BUSY):
  - Reads: cpu_dout <= mem_dout. Writes leave cpu_dout unchanged.
  - cpu_pending cleared.
  - Next cycle: cpu_dout valid and cpu_wait=0.
- Loader completion (mem_ack in LDR_BUSY):
  - ldr_ack=1 for exactly the next cycle.
  - If ldr_req fell during LDR_BUSY, the access still completes and ldr_ack still pulses.
- Latency (strobe at cycle 0, memory acks at cycle k): mem_req high at cycle 1; cpu_wait low and data valid at k+1. Minimum is k=1, wait deasserts at cycle 2.
- Starvation counter (4 bits):
  - +1 on each CPU grant while ldr_req=1, saturating at STARVE_MAX.
  - Cleared on loader grant or whenever ldr_req=0.
- Boundary conditions:
  - mem_ack in IDLE: ignored; this includes a late ack after reset.
  - accept and ldr_req in same IDLE cycle: CPU wins unless starve==STARVE_MAX.
  - accept during LDR_BUSY: latched and pending; cpu_wait holds until the CPU access completes after the loader.
  - Reset mid-transaction: mem_req drops at the reset edge; pending CPU request and loader grant are discarded; cpu_wait goes low.
  - cpu_cs=0 strobes (unmapped): not accepted; cpu_wait stays 0; cpu_dout unchanged.

Test Plan:
- CPU read: cpu_req/cpu_rd/cpu_cs at addr 27'h0004123, mem_ack at cycle 3 with mem_dout=8'h5A -> mem_req cycles 1-3 with addr 27'h0004123, mem_we=0; cpu_wait high cycles 0-3, low at cycle 4 with cpu_dout=8'h5A.
- Loader burst: ldr_req held for addrs 0..3 with data 8'h10..8'h13, mem_ack 2 cycles after each mem_req -> four writes in order, mem_we=1, mem_req low ≥1 cycle between them, four single-cycle ldr_ack pulses.
- Simultaneous: accept and ldr_req in same IDLE cycle, starve=0 -> CPU served first; loader granted the IDLE cycle after CPU ack; starve cleared.
- Starvation, STARVE_MAX=4: ldr_req held and CPU re-requests every time it is released -> grant order CPU,CPU,CPU,CPU,LDR,CPU...
- Unmapped and ignored events: cpu_req with cpu_cs=0 -> no mem_req, cpu_wait=0, cpu_dout stays 8'hFF; stray mem_ack in IDLE -> no state change.
- Reset mid-access: assert reset during CPU_BUSY, then mem_ack arrives 2 cycles later -> mem_req=0 after the reset edge, cpu_wait=0, cpu_dout=8'hFF, ack ignored, next request serviced normally.

Source files
------------

// File: rtl/mapper_mem_arbiter.sv
// rtl/mapper_mem_arbiter.sv - shares one ROM/RAM port between the mapped CPU and the image loader
module mapper_mem_arbiter #(
    parameter int ADDR_W     = 27,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_cs,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              cpu_wait,
    input  logic              ldr_req,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [7:0]        ldr_din,
    output logic              ldr_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    input  logic [7:0]        mem_dout,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {IDLE, CPU_BUSY, LDR_BUSY} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t              state_q, state_d;
    logic                cpu_pending_q, cpu_pending_d;
    logic [ADDR_W-1:0]   cpu_addr_q, cpu_addr_d;
    logic [7:0]          cpu_din_q, cpu_din_d;
    logic                cpu_wr_q, cpu_wr_d;
    logic [3:0]          starve_q, starve_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]          mem_din_q, mem_din_d;
    logic                ldr_ack_q, ldr_ack_d;
    logic [7:0]          cpu_dout_q, cpu_dout_d;

    logic accept;
    logic ldr_live;
    logic starve_full;

    assign accept = cpu_req & cpu_cs & (cpu_rd | cpu_wr) & ~cpu_pending_q;
    // The loader still holds ldr_req with the old address while it sees ldr_ack,
    // so that cycle must not start a second loader access.
    assign ldr_live    = ldr_req & ~ldr_ack_q;
    assign starve_full = ldr_live & (starve_q == STARVE_LIM);

    assign cpu_wait = cpu_pending_q | accept;
    assign cpu_dout = cpu_dout_q;
    assign ldr_ack  = ldr_ack_q;
    assign mem_req  = mem_req_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;

    always_comb begin
        state_d       = state_q;
        cpu_pending_d = cpu_pending_q;
        cpu_addr_d    = cpu_addr_q;
        cpu_din_d     = cpu_din_q;
        cpu_wr_d      = cpu_wr_q;
        starve_d      = starve_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_din_d     = mem_din_q;
        ldr_ack_d     = 1'b0;
        cpu_dout_d    = cpu_dout_q;

        if (accept) begin
            cpu_pending_d = 1'b1;
            cpu_addr_d    = cpu_addr;
            cpu_din_d     = cpu_din;
            cpu_wr_d      = cpu_wr;
        end

        case (state_q)
            IDLE: begin
                if ((cpu_pending_q | accept) & ~starve_full) begin
                    state_d    = CPU_BUSY;
                    mem_req_d  = 1'b1;
                    mem_we_d   = accept ? cpu_wr   : cpu_wr_q;
                    mem_addr_d = accept ? cpu_addr : cpu_addr_q;
                    mem_din_d  = accept ? cpu_din  : cpu_din_q;
                    if (ldr_req && (starve_q != STARVE_LIM)) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else if (ldr_live) begin
                    state_d    = LDR_BUSY;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b1;
                    mem_addr_d = ldr_addr;
                    mem_din_d  = ldr_din;
                    starve_d   = 4'd0;
                end
            end
            CPU_BUSY: begin
                if (mem_ack) begin
                    state_d       = IDLE;
                    mem_req_d     = 1'b0;
                    mem_we_d      = 1'b0;
                    cpu_pending_d = 1'b0;
                    if (!cpu_wr_q) begin
                        cpu_dout_d = mem_dout;
                    end
                end
            end
            LDR_BUSY: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    ldr_ack_d = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase

        if (!ldr_req) begin
            starve_d = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cpu_pending_q <= 1'b0;
            cpu_addr_q    <= '0;
            cpu_din_q     <= 8'h00;
            cpu_wr_q      <= 1'b0;
            starve_q      <= 4'd0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_din_q     <= 8'h00;
            ldr_ack_q     <= 1'b0;
            cpu_dout_q    <= 8'hFF;
        end else begin
            state_q       <= state_d;
            cpu_pending_q <= cpu_pending_d;
            cpu_addr_q    <= cpu_addr_d;
            cpu_din_q     <= cpu_din_d;
            cpu_wr_q      <= cpu_wr_d;
            starve_q      <= starve_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_din_q     <= mem_din_d;
            ldr_ack_q     <= ldr_ack_d;
            cpu_dout_q    <= cpu_dout_d;
        end
    end

endmodule

// File: tb/tb_mapper_mem_arbiter.sv
// tb/tb_mapper_mem_arbiter.sv - scoreboard bench for mapper_mem_arbiter
module tb_mapper_mem_arbiter;

    localparam int ADDR_W = 27;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        din;
    } mem_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cpu_req = 1'b0;
    logic              cpu_cs = 1'b0;
    logic              cpu_rd = 1'b0;
    logic              cpu_wr = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [7:0]        cpu_din = 8'h00;
    logic [7:0]        cpu_dout;
    logic              cpu_wait;
    logic              ldr_req = 1'b0;
    logic [ADDR_W-1:0] ldr_addr = '0;
    logic [7:0]        ldr_din = 8'h00;
    logic              ldr_ack;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic              mem_ack;

    int   n_chk = 0;
    int   n_fail = 0;
    mem_t exp_mem[$];
    logic [7:0] exp_rd[$];
    logic [7:0] model_dout = 8'hFF;
    int   ack_dly = 3;
    bit   resp_en = 1'b1;
    int   stray_req = 0;

    mapper_mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_cs(cpu_cs), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_wait(cpu_wait),
        .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_din(ldr_din), .ldr_ack(ldr_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_ack(mem_ack)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] data_fn(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ 8'h79;
    endfunction

    function automatic void push_mem(input logic we, input logic [ADDR_W-1:0] a, input logic [7:0] d);
        mem_t t;
        t.we = we; t.addr = a; t.din = d;
        exp_mem.push_back(t);
    endfunction

    // Memory model: acks ack_dly cycles into each request, checks grants against the scoreboard.
    initial begin
        int   cnt;
        bit   in_txn;
        bit   stray_active;
        int   stray_done;
        mem_t t;
        mem_ack = 1'b0; mem_dout = 8'h00;
        cnt = 0; in_txn = 1'b0; stray_active = 1'b0; stray_done = 0;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 1'b0;
                if (!stray_active) chk("mem_req_gap", {31'd0, mem_req}, 32'd0);
                stray_active = 1'b0;
            end else if (stray_req != stray_done) begin
                stray_done++;
                mem_ack = 1'b1; mem_dout = 8'hC3; stray_active = 1'b1;
            end else if (resp_en && mem_req) begin
                if (!in_txn) begin
                    in_txn = 1'b1; cnt = 0;
                    if (exp_mem.size() == 0) begin
                        chk("mem_unexpected_grant", 32'd1, 32'd0);
                    end else begin
                        t = exp_mem.pop_front();
                        chk("mem_we", {31'd0, mem_we}, {31'd0, t.we});
                        chk("mem_addr", {5'd0, mem_addr}, {5'd0, t.addr});
                        chk("mem_din", {24'd0, mem_din}, {24'd0, t.din});
                    end
                end
                cnt++;
                if (cnt >= ack_dly) begin
                    mem_ack = 1'b1; mem_dout = data_fn(mem_addr); in_txn = 1'b0;
                end
            end else begin
                in_txn = 1'b0;
            end
        end
    end

    // Call at a negedge; returns at the negedge where cpu_wait is low, cyc = cycles since strobe.
    task automatic cpu_access(input logic wr, input logic [ADDR_W-1:0] a, input logic [7:0] d, output int cyc);
        logic [7:0] e;
        e = wr ? model_dout : data_fn(a);
        model_dout = e;
        exp_rd.push_back(e);
        cpu_req = 1'b1; cpu_cs = 1'b1; cpu_rd = !wr; cpu_wr = wr; cpu_addr = a; cpu_din = wr ? d : 8'h00;
        @(negedge clk);
        cpu_req = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0;
        cyc = 1;
        while (cpu_wait && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (cpu_wait) chk("cpu_wait_timeout", 32'd1, 32'd0);
        if (exp_rd.size() == 0) chk("cpu_rd_queue_empty", 32'd1, 32'd0);
        else chk("cpu_dout", {24'd0, cpu_dout}, {24'd0, exp_rd.pop_front()});
    endtask

    task automatic ldr_burst(input logic [ADDR_W-1:0] base, input int n, input logic [7:0] dbase);
        int cnt;
        ldr_req = 1'b1; ldr_addr = base; ldr_din = dbase;
        for (int i = 0; i < n; i++) begin
            cnt = 0;
            @(negedge clk);
            while (!ldr_ack && cnt < 200) begin
                @(negedge clk);
                cnt++;
            end
            if (!ldr_ack) chk("ldr_ack_timeout", 32'd1, 32'd0);
            if (i < n - 1) begin
                ldr_addr = ldr_addr + 1'b1;
                ldr_din  = ldr_din + 8'd1;
            end else begin
                ldr_req = 1'b0;
            end
            @(negedge clk);
            chk("ldr_ack_pulse", {31'd0, ldr_ack}, 32'd0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", {5'd0, mem_addr}, 32'd0);
        chk("rst_mem_din", {24'd0, mem_din}, 32'd0);
        chk("rst_ldr_ack", {31'd0, ldr_ack}, 32'd0);
        chk("rst_cpu_dout", {24'd0, cpu_dout}, 32'h00FF);
        chk("rst_cpu_wait", {31'd0, cpu_wait}, 32'd0);

        // Unmapped strobe and stray ack in IDLE
        @(negedge clk);
        cpu_req = 1'b1; cpu_cs = 1'b0; cpu_rd = 1'b1; cpu_addr = 27'h0000777;
        #1 chk("unmap_wait_c0", {31'd0, cpu_wait}, 32'd0);
        @(negedge clk);
        cpu_req = 1'b0; cpu_rd = 1'b0;
        #1 chk("unmap_mem_req", {31'd0, mem_req}, 32'd0);
        stray_req++;
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("stray_mem_req", {31'd0, mem_req}, 32'd0);
            chk("stray_wait", {31'd0, cpu_wait}, 32'd0);
            chk("stray_ldr_ack", {31'd0, ldr_ack}, 32'd0);
        end
        chk("unmap_cpu_dout", {24'd0, cpu_dout}, 32'h00FF);

        // Cycle-accurate CPU read
        @(negedge clk);
        ack_dly = 3;
        push_mem(1'b0, 27'h0004123, 8'h00);
        cpu_req = 1'b1; cpu_cs = 1'b1; cpu_rd = 1'b1; cpu_addr = 27'h0004123; cpu_din = 8'h00;
        #1;
        chk("rd_c0_wait", {31'd0, cpu_wait}, 32'd1);
        chk("rd_c0_mem_req", {31'd0, mem_req}, 32'd0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) begin cpu_req = 1'b0; cpu_rd = 1'b0; end
            #1;
            chk($sformatf("rd_c%0d_mem_req", c), {31'd0, mem_req}, 32'd1);
            chk($sformatf("rd_c%0d_addr", c), {5'd0, mem_addr}, 32'h0004123);
            chk($sformatf("rd_c%0d_we", c), {31'd0, mem_we}, 32'd0);
            chk($sformatf("rd_c%0d_wait", c), {31'd0, cpu_wait}, 32'd1);
        end
        @(negedge clk);
        #1;
        chk("rd_c4_wait", {31'd0, cpu_wait}, 32'd0);
        chk("rd_c4_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rd_c4_dout", {24'd0, cpu_dout}, 32'h005A);
        model_dout = 8'h5A;

        // Minimum latency read, then a write that must leave cpu_dout alone
        @(negedge clk);
        ack_dly = 1;
        push_mem(1'b0, 27'h0000010, 8'h00);
        cpu_access(1'b0, 27'h0000010, 8'h00, cyc);
        chk("min_latency", cyc, 32'd2);
        ack_dly = 2;
        push_mem(1'b1, 27'h1234567, 8'hE7);
        cpu_access(1'b1, 27'h1234567, 8'hE7, cyc);
        chk("wr_latency", cyc, 32'd3);

        // Loader burst
        @(negedge clk);
        ack_dly = 3;
        for (int i = 0; i < 4; i++) push_mem(1'b1, 27'(i), 8'(8'h10 + i));
        ldr_burst(27'h0, 4, 8'h10);

        // Simultaneous CPU strobe and loader request
        @(negedge clk);
        ack_dly = 2;
        push_mem(1'b0, 27'h0000100, 8'h00);
        push_mem(1'b1, 27'h0000200, 8'h77);
        fork
            begin int cc; cpu_access(1'b0, 27'h0000100, 8'h00, cc); end
            ldr_burst(27'h0000200, 1, 8'h77);
        join

        // Starvation: CPU re-requests every release; grant order C,C,C,C,L,C
        @(negedge clk);
        ack_dly = 1;
        for (int i = 0; i < 4; i++) push_mem(1'b0, 27'(27'h400 + i), 8'h00);
        push_mem(1'b1, 27'h0000300, 8'hA5);
        push_mem(1'b0, 27'h0000404, 8'h00);
        fork
            begin
                int cc;
                for (int i = 0; i < 5; i++) cpu_access(1'b0, 27'(27'h400 + i), 8'h00, cc);
            end
            ldr_burst(27'h0000300, 1, 8'hA5);
        join

        // Reset in the middle of a CPU access, late ack afterwards
        @(negedge clk);
        resp_en = 1'b0;
        cpu_req = 1'b1; cpu_cs = 1'b1; cpu_rd = 1'b1; cpu_addr = 27'h0ABCDE;
        @(negedge clk);
        cpu_req = 1'b0; cpu_rd = 1'b0;
        #1 chk("mid_mem_req", {31'd0, mem_req}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("mid_rst_wait", {31'd0, cpu_wait}, 32'd0);
        chk("mid_rst_dout", {24'd0, cpu_dout}, 32'h00FF);
        model_dout = 8'hFF;
        @(negedge clk);
        stray_req++;
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("late_ack_mem_req", {31'd0, mem_req}, 32'd0);
            chk("late_ack_dout", {24'd0, cpu_dout}, 32'h00FF);
        end
        @(negedge clk);
        resp_en = 1'b1;
        ack_dly = 2;
        push_mem(1'b0, 27'h0000055, 8'h00);
        cpu_access(1'b0, 27'h0000055, 8'h00, cyc);
        chk("post_rst_latency", cyc, 32'd3);

        repeat (4) @(negedge clk);
        chk("exp_mem_drained", exp_mem.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
